pwm_duty_controller: RTL and testbench
======================================

# pwm_duty_controller

Downstream consumer of the debounced push-button pulses. It turns "increase" and "decrease" button pulses into a saturating duty-cycle register and generates the PWM output from it. Button pulses arrive from the debouncer on its slow-clock timebase and are edge-detected here on the fast system clock, so each press changes the duty exactly once.

## Interface
- `PWM_PERIOD`, default 1000: PWM period in `clk` cycles; must be ≥ 2.
- `STEP`, default 100: duty change per button event; must be ≥ 1.
- `DUTY_INIT`, default 500: duty after reset; must be ≤ `PWM_PERIOD`.
- `DW`, derived as `$clog2(PWM_PERIOD+1)`: width of the duty and the counter.
- `clk`  input  1: system clock. Single clock domain; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `inc_pb`  input  1: debounced increase pulse; may stay high for many `clk` cycles.
- `dec_pb`  input  1: debounced decrease pulse; same behaviour as `inc_pb`.
- `pwm_out`  output  1: registered PWM output.
- `duty`  output  DW: current requested duty in cycles, range 0..`PWM_PERIOD`.
- `at_max`  output  1: high when `duty == PWM_PERIOD`.
- `at_min`  output  1: high when `duty == 0`.

## Operation
- Each button input passes through a 2-FF synchronizer and then a third "previous" FF.
- An event is the rising edge seen between the second and third FF.
  - A level held high for any length of time produces one event.
  - The input must be sampled low at least once before it can produce another event.
- Duty update when an event occurs:
  - inc event only: `duty <= min(duty + STEP, PWM_PERIOD)`. Compute in DW+1 bits; no wrap.
  - dec event only: `duty <= (duty < STEP) ? 0 : duty - STEP`. No underflow.
  - inc and dec events in the same cycle: no change; both events are consumed.
- Period counter `cnt` counts 0..`PWM_PERIOD-1` and wraps to 0.
- On the edge where `cnt == PWM_PERIOD-1`, `duty_active <= duty`.
- `pwm_out <= (cnt < duty_active)`.
  - `duty_active == 0` gives a constant low output.
  - `duty_active == PWM_PERIOD` gives a constant high output.
- `at_max` and `at_min` are combinational decodes of the `duty` register.
- Reset values:
  - `cnt = 0`
  - `duty = duty_active = DUTY_INIT`
  - `pwm_out = 0`
  - all synchronizer and previous FFs = 0
  - `at_max` / `at_min` follow `DUTY_INIT`
- Reset mid-period takes effect at the next edge and discards any pending event in the synchronizer.
- A button held high across reset release produces one event after release.

## Timing
- Event latency: if `inc_pb`/`dec_pb` is first sampled high at edge k, `duty` changes at edge k+2.
- `pwm_out` lags `cnt` by one cycle.
  - The first high cycle of a period is the cycle after the one where `cnt == 0`.
  - High time per period is exactly `duty_active` cycles.
- A duty change becomes visible on `pwm_out` from the first full period after the next wrap (shadowed build).
- No handshake exists; events are never back-pressured or queued.
- `duty` changes by at most one STEP per cycle.

## Configuration
- `PWM_DUTY_SHADOW_EN` defined:
  - `duty_active` loads only at period wrap, as described above.
  - Glitch-free; the current period always completes with its old high time.
- `PWM_DUTY_SHADOW_EN` undefined:
  - `duty_active` is removed and the compare uses `duty` directly.
  - A change applies from the next edge, mid-period, and may shorten or extend the current pulse.
- All other behaviour is identical in both builds.

## Test plan
Bench parameters: `PWM_PERIOD=10`, `STEP=3`, `DUTY_INIT=5`; shadow enabled unless stated.
- Reset held 3 cycles, then released: `duty=5`, `pwm_out=0` during reset; afterwards `pwm_out` is high for exactly 5 of every 10 cycles, `at_max=at_min=0`.
- `inc_pb` high for 20 cycles, low for 5, then high again: `duty` goes 5→8 (once, 2 edges after first sample), then 8→10 with `at_max=1`; after the next wrap `pwm_out` is constant high; a further press keeps `duty=10`.
- Two `dec_pb` presses from reset: `duty` goes 5→2→0, `at_min=1`; `pwm_out` is constant low from the following period.
- `inc_pb` and `dec_pb` rise on the same edge: `duty` stays 5, both events are consumed, and `pwm_out` is unchanged.
- One inc press landing at `cnt=2`:
  - Shadowed build: current period still high 5 cycles, next period high 8.
  - Build without `PWM_DUTY_SHADOW_EN`: high time changes within the current period.
- `rst` asserted mid-period with `duty=8` and a press in flight in the synchronizer: at the next edge all reset values are restored and `duty=5`; no event is applied unless the button is still high after release.

Source files
------------

// File: rtl/pwm_duty_controller.sv
// Button-driven saturating duty register and registered PWM generator.
// Define PWM_DUTY_SHADOW_EN to latch the duty only at period wrap (glitch-free PWM).
module pwm_duty_controller #(
    parameter int PWM_PERIOD = 1000,
    parameter int STEP = 100,
    parameter int DUTY_INIT = 500,
    localparam int DW = $clog2(PWM_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_pb,
    input  logic          dec_pb,
    output logic          pwm_out,
    output logic [DW-1:0] duty,
    output logic          at_max,
    output logic          at_min
);

    // A step larger than the period saturates identically in both directions.
    localparam int            STEP_SAT = (STEP > PWM_PERIOD) ? PWM_PERIOD : STEP;
    localparam logic [DW:0]   STEP_W   = (DW + 1)'(STEP_SAT);
    localparam logic [DW:0]   PERIOD_W = (DW + 1)'(PWM_PERIOD);
    localparam logic [DW-1:0] STEP_D   = DW'(STEP_SAT);
    localparam logic [DW-1:0] PERIOD_D = DW'(PWM_PERIOD);
    localparam logic [DW-1:0] CNT_MAX  = DW'(PWM_PERIOD - 1);
    localparam logic [DW-1:0] INIT_D   = DW'(DUTY_INIT);

    logic [1:0]    inc_sync_q, dec_sync_q;
    logic          inc_prev_q, dec_prev_q;
    logic          inc_evt, dec_evt;
    logic [DW:0]   sum_w;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cmp_duty;
    logic          pwm_q, pwm_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            inc_sync_q <= '0;
            dec_sync_q <= '0;
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
        end else begin
            inc_sync_q <= {inc_sync_q[0], inc_pb};
            dec_sync_q <= {dec_sync_q[0], dec_pb};
            inc_prev_q <= inc_sync_q[1];
            dec_prev_q <= dec_sync_q[1];
        end
    end

    // Simultaneous inc and dec events cancel; both are consumed.
    always_comb begin
        inc_evt = inc_sync_q[1] & ~inc_prev_q;
        dec_evt = dec_sync_q[1] & ~dec_prev_q;
        sum_w   = {1'b0, duty_q} + STEP_W;
        duty_d  = duty_q;
        if (inc_evt && !dec_evt) begin
            duty_d = (sum_w > PERIOD_W) ? PERIOD_D : sum_w[DW-1:0];
        end else if (dec_evt && !inc_evt) begin
            duty_d = ({1'b0, duty_q} < STEP_W) ? '0 : duty_q - STEP_D;
        end
    end

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + DW'(1);
        pwm_d = (cnt_q < cmp_duty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= INIT_D;
            cnt_q  <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            cnt_q  <= cnt_d;
            pwm_q  <= pwm_d;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [DW-1:0] duty_active_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_active_q <= INIT_D;
        end else if (cnt_q == CNT_MAX) begin
            duty_active_q <= duty_q;
        end
    end

    assign cmp_duty = duty_active_q;
`else
    assign cmp_duty = duty_q;
`endif

    assign pwm_out = pwm_q;
    assign duty    = duty_q;
    assign at_max  = (duty_q == PERIOD_D);
    assign at_min  = (duty_q == '0);

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Directed bench for pwm_duty_controller with PWM_PERIOD=10, STEP=3, DUTY_INIT=5.
module tb_pwm_duty_controller;

    localparam int PWM_PERIOD = 10;
    localparam int STEP = 3;
    localparam int DUTY_INIT = 5;
    localparam int DW = $clog2(PWM_PERIOD + 1);

    logic          clk;
    logic          rst;
    logic          inc_pb;
    logic          dec_pb;
    logic          pwm_out;
    logic [DW-1:0] duty;
    logic          at_max;
    logic          at_min;

    int total;
    int bad;
    int n;

    pwm_duty_controller #(
        .PWM_PERIOD(PWM_PERIOD),
        .STEP(STEP),
        .DUTY_INIT(DUTY_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inc_pb(inc_pb),
        .dec_pb(dec_pb),
        .pwm_out(pwm_out),
        .duty(duty),
        .at_max(at_max),
        .at_min(at_min)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic count_high(input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            step();
            hi += int'(pwm_out);
        end
    endtask

    // Leaves the bench one falling edge after the last reset edge (cnt=0).
    task automatic do_reset(input string tag);
        rst = 1'b1;
        inc_pb = 1'b0;
        dec_pb = 1'b0;
        repeat (3) step();
        check({tag, "_rst_duty"}, int'(duty), DUTY_INIT);
        check({tag, "_rst_pwm"}, int'(pwm_out), 0);
        check({tag, "_rst_max"}, int'(at_max), 0);
        check({tag, "_rst_min"}, int'(at_min), 0);
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        inc_pb = 1'b0;
        dec_pb = 1'b0;

        // Reset, then two idle periods at 5/10.
        do_reset("t1");
        count_high(10, n);
        check("t1_period0_high", n, 5);
        count_high(10, n);
        check("t1_period1_high", n, 5);

        // Increase to 8, then saturate at 10.
        do_reset("t2");
        inc_pb = 1'b1;
        step(); step();
        check("t2_duty_before", int'(duty), 5);
        step();
        check("t2_duty_8", int'(duty), 8);
        repeat (7) step();
        count_high(10, n);
        check("t2_period1_high", n, 8);
        check("t2_held_no_repeat", int'(duty), 8);
        inc_pb = 1'b0;
        repeat (5) step();
        inc_pb = 1'b1;
        step(); step();
        check("t2_duty_still_8", int'(duty), 8);
        step();
        check("t2_duty_10", int'(duty), 10);
        check("t2_at_max", int'(at_max), 1);
        step(); step();
        count_high(10, n);
        check("t2_full_high", n, 10);
        inc_pb = 1'b0;
        repeat (3) step();
        inc_pb = 1'b1;
        repeat (4) step();
        check("t2_sat_duty", int'(duty), 10);
        check("t2_sat_max", int'(at_max), 1);
        inc_pb = 1'b0;

        // Two decreases: 5 -> 2 -> 0.
        do_reset("t3");
        dec_pb = 1'b1;
        repeat (3) step();
        check("t3_duty_2", int'(duty), 2);
        step();
        dec_pb = 1'b0;
        step(); step();
        dec_pb = 1'b1;
        repeat (3) step();
        check("t3_duty_0", int'(duty), 0);
        check("t3_at_min", int'(at_min), 1);
        dec_pb = 1'b0;
        step();
        count_high(10, n);
        check("t3_zero_high", n, 0);
        check("t3_underflow_none", int'(duty), 0);

        // Simultaneous inc and dec cancel.
        do_reset("t4");
        inc_pb = 1'b1;
        dec_pb = 1'b1;
        repeat (5) step();
        check("t4_duty_same", int'(duty), 5);
        inc_pb = 1'b0;
        dec_pb = 1'b0;
        repeat (5) step();
        count_high(10, n);
        check("t4_period_high", n, 5);
        check("t4_duty_after", int'(duty), 5);

        // Inc lands at cnt=2 of period 1.
        do_reset("t5");
        repeat (9) step();
        inc_pb = 1'b1;
        step();
        count_high(10, n);
`ifdef PWM_DUTY_SHADOW_EN
        check("t5_cur_period_high", n, 5);
`else
        check("t5_cur_period_high", n, 8);
`endif
        inc_pb = 1'b0;
        count_high(10, n);
        check("t5_next_period_high", n, 8);

        // Reset mid-period with a press in flight.
        do_reset("t6");
        inc_pb = 1'b1;
        repeat (3) step();
        inc_pb = 1'b0;
        repeat (5) step();
        check("t6_duty_8", int'(duty), 8);
        inc_pb = 1'b1;
        step();
        inc_pb = 1'b0;
        rst = 1'b1;
        step();
        check("t6_rst_duty", int'(duty), 5);
        check("t6_rst_pwm", int'(pwm_out), 0);
        check("t6_rst_max", int'(at_max), 0);
        rst = 1'b0;
        count_high(10, n);
        check("t6_post_high", n, 5);
        check("t6_no_event", int'(duty), 5);

        // Button held across reset release gives one event.
        inc_pb = 1'b1;
        rst = 1'b1;
        step(); step();
        check("t6_held_rst_duty", int'(duty), 5);
        rst = 1'b0;
        step(); step();
        check("t6_held_wait", int'(duty), 5);
        step();
        check("t6_held_event", int'(duty), 8);
        repeat (4) step();
        check("t6_held_once", int'(duty), 8);
        inc_pb = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
